// File: rtl/sipo_deserializer_if.sv
// Parallel output port of the serial-in parallel-out receiver: word, valid/ready handshake and status flags.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overflow;
    logic             parity_err;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready,
        output overflow,
        output parity_err
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready,
        input  overflow,
        input  parity_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: rebuilds WIDTH-bit words from sin/start and holds one word on a valid/ready port.
// Optional trailing even-parity bit is enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sin,
    input  logic                start,
    sipo_deserializer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic             write_c;
    logic             complete_c;
    int unsigned      frame_pos;
    int unsigned      slot;
    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] result_word_c;
    logic             result_perr_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; start always opens a new frame, aborting any partial one
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                if (start) begin
                    state_next = SHIFT;
                end else if (cnt == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                state_next = start ? SHIFT : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Control strobes: capture a data bit, and finish a word
    always_comb begin
        write_c    = start || (state == SHIFT);
`ifdef SIPO_PARITY_EN
        complete_c = (state == PARITY) && !start;
`else
        complete_c = (state == SHIFT) && !start && (cnt == LAST_CNT);
`endif
    end

    // Place the incoming bit at its frame position; a new frame starts from a cleared register
    always_comb begin
        frame_pos = start ? 0 : 32'(cnt);
        slot      = MSB_FIRST ? (WIDTH - 1 - frame_pos) : frame_pos;
        word_c    = start ? '0 : shreg;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (write_c && (i == slot)) word_c[i] = sin;
        end
    end

`ifdef SIPO_PARITY_EN
    assign result_word_c = shreg;
    assign result_perr_c = ^{shreg, sin};
`else
    assign result_word_c = word_c;
    assign result_perr_c = 1'b0;
`endif

    // Bit counter and assembly register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else begin
            if (start) begin
                cnt <= CNT_W'(1);
            end else if (state == SHIFT) begin
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
            end
            if (write_c) shreg <= word_c;
        end
    end

    // One-word output holding register; a word finishing into a full, unaccepted slot is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.parity_err <= 1'b0;
        end else if (complete_c) begin
            if (!bus.dout_valid || bus.dout_ready) begin
                bus.dout       <= result_word_c;
                bus.parity_err <= result_perr_c;
                bus.dout_valid <= 1'b1;
            end else begin
                bus.overflow <= 1'b1;
            end
        end else if (bus.dout_valid && bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
        end
    end

endmodule
